// File: rtl/vector_seq_ctrl.sv
// Load/replay sequencer for the per-dimension vector buffer: loads one vector
// starting at slot 0 of the free-running buffer and replays it NUM_PASSES times.
module vector_seq_ctrl #(
    parameter int NUM_DIMENSIONS = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_PASSES     = 4,
    localparam int IDX_W  = (NUM_DIMENSIONS > 2) ? $clog2(NUM_DIMENSIONS) : 1,
    localparam int PASS_W = (NUM_PASSES > 2) ? $clog2(NUM_PASSES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  underrun,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  fifo_rst,
    output logic                  fifo_load,
    output logic [DATA_WIDTH-1:0] fifo_data,
    output logic [IDX_W-1:0]      elem_idx,
    output logic                  pass_valid,
    output logic                  pass_first,
    output logic                  pass_last,
    output logic [PASS_W-1:0]     pass_num
);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        LOAD,
        REPLAY,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_DIMENSIONS - 1);
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASSES - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [PASS_W-1:0]   pass_q, pass_d;
    logic                idx_at_last;

    assign idx_at_last = (idx_q == LAST_IDX);

    // The mirror index must stay phase-locked to the buffer's own slot counter,
    // so it only ever counts; the FSM waits for slot N-1 instead of steering it.
    always_comb begin
        idx_d   = idx_at_last ? '0 : idx_q + IDX_W'(1);
        state_d = state_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = idx_at_last ? LOAD : ARM;
                end
            end
            ARM: begin
                if (idx_at_last) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (!in_valid) begin
                    state_d = ARM;
                end else if (idx_at_last) begin
                    state_d = REPLAY;
                    pass_d  = '0;
                end
            end
            REPLAY: begin
                if (idx_at_last) begin
                    if (pass_q == LAST_PASS) begin
                        state_d = DONE;
                    end else begin
                        pass_d = pass_q + PASS_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pass_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
        end
    end

    assign fifo_rst   = ~rst;
    assign in_ready   = (state_q == LOAD);
    assign fifo_load  = (state_q == LOAD) && in_valid;
    assign fifo_data  = in_data;
    assign underrun   = (state_q == LOAD) && !in_valid;
    assign pass_valid = (state_q == REPLAY);
    assign pass_first = pass_valid && (idx_q == '0);
    assign pass_last  = pass_valid && idx_at_last;
    assign pass_num   = pass_q;
    assign done       = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign elem_idx   = idx_q;

endmodule

// File: tb/tb_vector_seq_ctrl.sv
// Bench for vector_seq_ctrl: a behavioural buffer + sequencer model checked every
// cycle, directed load/replay/underrun/reset cases and a large N=32, P=4 instance.
module tb_vector_seq_ctrl;

    localparam int N  = 4;
    localparam int P  = 2;
    localparam int DW = 32;

    localparam int M_IDLE   = 0;
    localparam int M_WAIT   = 1;
    localparam int M_LOAD   = 2;
    localparam int M_REPLAY = 3;
    localparam int M_DONE   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          busy, done, underrun, in_ready, fifo_rst, fifo_load;
    logic [DW-1:0] fifo_data;
    logic [1:0]    elem_idx;
    logic          pass_valid, pass_first, pass_last;
    logic [0:0]    pass_num;

    logic          rst32 = 1'b0;
    logic          start32 = 1'b1;
    logic          in_valid32 = 1'b1;
    logic [DW-1:0] in_data32 = 32'h5A5A_0000;
    logic          busy32, done32, underrun32, in_ready32, fifo_rst32, fifo_load32;
    logic [DW-1:0] fifo_data32;
    logic [4:0]    elem_idx32;
    logic          pass_valid32, pass_first32, pass_last32;
    logic [1:0]    pass_num32;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vector_seq_ctrl #(.NUM_DIMENSIONS(N), .DATA_WIDTH(DW), .NUM_PASSES(P)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .underrun(underrun), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .fifo_rst(fifo_rst), .fifo_load(fifo_load),
        .fifo_data(fifo_data), .elem_idx(elem_idx), .pass_valid(pass_valid),
        .pass_first(pass_first), .pass_last(pass_last), .pass_num(pass_num)
    );

    vector_seq_ctrl #(.NUM_DIMENSIONS(32), .DATA_WIDTH(DW), .NUM_PASSES(4)) dut32 (
        .clk(clk), .rst(rst32), .start(start32), .busy(busy32), .done(done32),
        .underrun(underrun32), .in_valid(in_valid32), .in_ready(in_ready32),
        .in_data(in_data32), .fifo_rst(fifo_rst32), .fifo_load(fifo_load32),
        .fifo_data(fifo_data32), .elem_idx(elem_idx32), .pass_valid(pass_valid32),
        .pass_first(pass_first32), .pass_last(pass_last32), .pass_num(pass_num32)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: buffer with its own free-running slot, plus the command
    // sequence described as "wait for slot N-1, collect N elements, replay N*P".
    logic [DW-1:0] buf_mem [N];
    int            buf_slot = 0;
    logic [DW-1:0] buf_out = '0;
    int            m_idx = 0;
    int            m_mode = M_IDLE;
    int            m_rcnt = 0;
    logic [DW-1:0] m_burst [$];
    logic [DW-1:0] m_vec [N];
    bit            model_on = 1'b0;

    always @(posedge clk) begin
        if (fifo_rst) begin
            for (int k = 0; k < N; k++) buf_mem[k] = '0;
            buf_slot = 0;
        end else begin
            if (fifo_load) buf_mem[buf_slot] = fifo_data;
            buf_slot = (buf_slot + 1) % N;
        end
        buf_out = buf_mem[buf_slot];

        if (!rst) begin
            m_idx  = 0;
            m_mode = M_IDLE;
            m_rcnt = 0;
            m_burst.delete();
        end else begin
            case (m_mode)
                M_IDLE: if (start) m_mode = (m_idx == N - 1) ? M_LOAD : M_WAIT;
                M_WAIT: if (m_idx == N - 1) m_mode = M_LOAD;
                M_LOAD: begin
                    if (!in_valid) begin
                        m_mode = M_WAIT;
                    end else begin
                        m_burst.push_back(in_data);
                        if (m_burst.size() == N) begin
                            for (int k = 0; k < N; k++) m_vec[k] = m_burst[k];
                            m_rcnt = 0;
                            m_mode = M_REPLAY;
                        end
                    end
                end
                M_REPLAY: begin
                    m_rcnt++;
                    if (m_rcnt == N * P) m_mode = M_DONE;
                end
                default: m_mode = M_IDLE;
            endcase
            if (m_mode != M_LOAD) m_burst.delete();
            m_idx = (m_idx + 1) % N;
        end
        model_on = 1'b1;
    end

    always @(negedge clk) begin
        if (model_on) begin
            checkOutput("fifo_rst", fifo_rst, !rst);
            checkOutput("elem_idx", elem_idx, m_idx);
            checkOutput("busy", busy, m_mode != M_IDLE);
            checkOutput("done", done, m_mode == M_DONE);
            checkOutput("in_ready", in_ready, m_mode == M_LOAD);
            checkOutput("fifo_load", fifo_load, (m_mode == M_LOAD) && in_valid);
            checkOutput("underrun", underrun, (m_mode == M_LOAD) && !in_valid);
            checkOutput("fifo_data", fifo_data, in_data);
            checkOutput("pass_valid", pass_valid, m_mode == M_REPLAY);
            checkOutput("pass_first", pass_first, (m_mode == M_REPLAY) && (m_rcnt % N == 0));
            checkOutput("pass_last", pass_last, (m_mode == M_REPLAY) && (m_rcnt % N == N - 1));
            if (m_mode == M_REPLAY) begin
                checkOutput("pass_num", pass_num, m_rcnt / N);
                checkOutput("replay_data", buf_out, m_vec[m_rcnt % N]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic v, input logic [DW-1:0] d);
        cyc();
        rst = r; start = s; in_valid = v; in_data = d;
        settle();
    endtask

    int            run_arm, run_load, run_rep, run_nf, run_done, run_under;
    int            run_done_i, run_last_i;
    logic          run_ready_after, run_busy_after;
    logic [1:0]    run_load_idx [16];
    logic [DW-1:0] run_rep_buf [64];
    int            run_first_pos [8];

    // One command from IDLE: start at slot start_idx, optional drop of in_valid at
    // LOAD slot drop_idx, optional start noise during LOAD/REPLAY; data = base + slot.
    task automatic runCommand(input int start_idx, input int drop_idx, input bit noisy, input logic [DW-1:0] base);
        bit started = 1'b0;
        bit dropped = 1'b0;
        int start_i = 0;
        run_arm = 0; run_load = 0; run_rep = 0; run_nf = 0; run_done = 0; run_under = 0;
        run_done_i = -1; run_last_i = -1; run_ready_after = 1'b0; run_busy_after = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cyc();
            rst = 1'b1;
            if (!started) start = (m_idx == start_idx) && (m_mode == M_IDLE);
            else start = noisy && (m_mode == M_LOAD || m_mode == M_REPLAY);
            in_valid = !(drop_idx >= 0 && !dropped && m_mode == M_LOAD && m_idx == drop_idx);
            in_data = base + DW'(m_idx);
            settle();
            if (!in_valid) begin
                dropped = 1'b1;
                checkOutput("underrun_pulse", underrun, 1);
                checkOutput("underrun_no_load", fifo_load, 0);
            end
            if (start && !started) begin
                started = 1'b1;
                start_i = i;
            end else if (started) begin
                if (i == start_i + 1) begin
                    run_ready_after = in_ready;
                    run_busy_after  = busy;
                end
                if (busy && !in_ready && !pass_valid && !done) run_arm++;
            end
            if (underrun) run_under++;
            if (fifo_load && run_load < 16) begin
                run_load_idx[run_load] = elem_idx;
                run_load++;
            end
            if (pass_valid && run_rep < 64) begin
                if (pass_first && run_nf < 8) begin
                    run_first_pos[run_nf] = run_rep;
                    run_nf++;
                end
                if (pass_last) run_last_i = i;
                run_rep_buf[run_rep] = buf_out;
                run_rep++;
            end
            if (done) begin
                run_done++;
                run_done_i = i;
            end
            if (run_done > 0 && !busy) break;
        end
        start = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] exp_seq [8];
        int            done_cnt;
        int            rc, last_done, nd;

        repeat (3) applyStimulus(0, 0, 0, '0);
        applyStimulus(1, 0, 0, '0);
        checkOutput("reset_idx", elem_idx, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_pass_num", pass_num, 0);

        // Basic load/replay with start at slot 1
        runCommand(1, -1, 0, 32'hA);
        exp_seq = '{32'hA, 32'hB, 32'hC, 32'hD, 32'hA, 32'hB, 32'hC, 32'hD};
        checkOutput("s1_arm_cycles", run_arm, 2);
        checkOutput("s1_load_count", run_load, 4);
        for (int k = 0; k < 4; k++) checkOutput("s1_load_slot", run_load_idx[k], k);
        checkOutput("s1_replay_len", run_rep, 8);
        for (int k = 0; k < 8; k++) checkOutput("s1_replay_data", run_rep_buf[k], exp_seq[k]);
        checkOutput("s1_first_count", run_nf, 2);
        checkOutput("s1_first0", run_first_pos[0], 0);
        checkOutput("s1_first1", run_first_pos[1], 4);
        checkOutput("s1_done_count", run_done, 1);
        checkOutput("s1_done_after_last", run_done_i, run_last_i + 1);

        // Start at slot N-1 goes straight to LOAD
        runCommand(3, -1, 0, 32'h20);
        checkOutput("s2_ready_next", run_ready_after, 1);
        checkOutput("s2_busy_next", run_busy_after, 1);
        checkOutput("s2_arm_cycles", run_arm, 0);
        checkOutput("s2_done_count", run_done, 1);

        // Broken burst at slot 2, then clean resend of 1,2,3,4
        runCommand(0, 2, 0, 32'h1);
        checkOutput("s3_underruns", run_under, 1);
        checkOutput("s3_load_count", run_load, 6);
        for (int k = 0; k < 4; k++) checkOutput("s3_replay_data", run_rep_buf[k], k + 1);
        checkOutput("s3_done_count", run_done, 1);

        // start pulses during LOAD/REPLAY are ignored
        runCommand(2, -1, 1, 32'h40);
        checkOutput("s4_done_count", run_done, 1);
        checkOutput("s4_replay_len", run_rep, 8);

        // Reset in the middle of pass 1
        applyStimulus(1, 1, 1, '0);
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1, 0, 1, 32'h7);
            if (pass_valid && pass_num == 1'b1) break;
        end
        checkOutput("s5_in_pass1", pass_valid && pass_num == 1'b1, 1);
        applyStimulus(0, 0, 1, 32'h7);
        checkOutput("s5_fifo_rst", fifo_rst, 1);
        applyStimulus(0, 0, 1, 32'h7);
        checkOutput("s5_busy", busy, 0);
        checkOutput("s5_idx", elem_idx, 0);
        checkOutput("s5_pass_valid", pass_valid, 0);
        checkOutput("s5_buf_out", buf_out, 0);
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 0, 1, 32'h7);
            if (done) done_cnt++;
        end
        checkOutput("s5_no_done", done_cnt, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 299) != 0, $urandom_range(0, 7) == 0,
                          $urandom_range(0, 15) != 0, $urandom);
        end
        applyStimulus(1, 0, 0, '0);

        // N=32, P=4 back-to-back commands
        cyc();
        rst32 = 1'b1;
        rc = 0; last_done = -1; nd = 0;
        for (int i = 0; i < 1200; i++) begin
            cyc();
            in_data32 = $urandom;
            settle();
            if (pass_valid32) begin
                checkOutput("big_pass_num", pass_num32, rc / 32);
                checkOutput("big_pass_first", pass_first32, rc % 32 == 0);
                checkOutput("big_pass_last", pass_last32, rc % 32 == 31);
                rc++;
            end else if (rc != 0) begin
                checkOutput("big_replay_len", rc, 128);
                rc = 0;
            end
            if (done32) begin
                if (last_done >= 0) checkOutput("big_done_spacing", i - last_done, 192);
                last_done = i;
                nd++;
                if (nd == 4) break;
            end
        end
        checkOutput("big_done_count", nd, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
